// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, pending-load scoreboard, sequential clear engine.
// Optional same-cycle read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0]           rd_data,
    output logic [NRD-1:0]                rd_busy,
    input  logic                          wa_en,
    input  logic [$clog2(NREG)-1:0]       wa_addr,
    input  logic [XLEN-1:0]               wa_data,
    input  logic                          wb_en,
    input  logic [$clog2(NREG)-1:0]       wb_addr,
    input  logic [XLEN-1:0]               wb_data,
    input  logic                          sb_set_en,
    input  logic [$clog2(NREG)-1:0]       sb_set_addr,
    input  logic                          clr_req,
    output logic                          clr_busy
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic            r_clr_busy;

    logic [XLEN-1:0] w_regs [NREG];
    logic [NREG-1:0] w_busy;
    logic            w_wa_go;
    logic            w_wb_go;
    logic            w_sb_go;
    logic            w_clearing;

    // All write sources are frozen while the clear engine owns the array.
    assign w_clearing = (r_state == ST_CLEAR);
    assign w_wa_go    = wa_en     & ~w_clearing;
    assign w_wb_go    = wb_en     & ~w_clearing;
    assign w_sb_go    = sb_set_en & ~w_clearing;
    assign clr_busy   = r_clr_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_clr_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state    <= ST_CLEAR;
                        r_idx      <= AW'(1);
                        r_clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_idx == AW'(NREG - 1)) begin
                        r_state    <= ST_IDLE;
                        r_idx      <= '0;
                        r_clr_busy <= 1'b0;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_idx      <= '0;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
                assign w_busy[gi] = 1'b0;
            end else begin : g_live
                logic [XLEN-1:0] r_q;
                logic            r_b;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_q <= '0;
                        r_b <= 1'b0;
                    end else if (w_clearing) begin
                        if (r_idx == AW'(gi)) begin
                            r_q <= '0;
                            r_b <= 1'b0;
                        end
                    end else begin
                        // Port B is the later writer and wins a same-address collision.
                        if (w_wb_go && wb_addr == AW'(gi))
                            r_q <= wb_data;
                        else if (w_wa_go && wa_addr == AW'(gi))
                            r_q <= wa_data;

                        if (w_sb_go && sb_set_addr == AW'(gi))
                            r_b <= 1'b1;
                        else if (w_wb_go && wb_addr == AW'(gi))
                            r_b <= 1'b0;
                    end
                end

                assign w_regs[gi] = r_q;
                assign w_busy[gi] = r_b;
            end
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rd
            wire [AW-1:0] w_a;
            assign w_a = rd_addr[gi*AW +: AW];
`ifdef REGFILE_MP_BYPASS_EN
            // Forward in-flight write data; the go signals already drop during a clear.
            assign rd_data[gi*XLEN +: XLEN] =
                (w_a != '0 && w_wb_go && wb_addr == w_a) ? wb_data :
                (w_a != '0 && w_wa_go && wa_addr == w_a) ? wa_data :
                w_regs[w_a];
`else
            assign rd_data[gi*XLEN +: XLEN] = w_regs[w_a];
`endif
            assign rd_busy[gi] = w_busy[w_a];
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: writes, collisions, busy tracking, bypass, clear, reset mid-clear.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wa_en = 1'b0;
    logic [AW-1:0]     wa_addr = '0;
    logic [XLEN-1:0]   wa_data = '0;
    logic              wb_en = 1'b0;
    logic [AW-1:0]     wb_addr = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              sb_set_en = 1'b0;
    logic [AW-1:0]     sb_set_addr = '0;
    logic              clr_req = 1'b0;
    logic              clr_busy;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] v;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wa_en = 1'b0; wb_en = 1'b0; sb_set_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic push(input string t, input logic [XLEN-1:0] v);
        sbq.push_back('{t, v});
    endtask

    task automatic chk(input logic [XLEN-1:0] obs);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed %h required an expectation", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset state
        tick(); tick();
        rd(5, 31);
        push("rst_clr_busy", 0);  chk(XLEN'(clr_busy));
        push("rst_data5", 0);     chk(rd_data[31:0]);
        push("rst_data31", 0);    chk(rd_data[63:32]);
        push("rst_busy", 0);      chk(XLEN'(rd_busy));
        rst = 1'b0;
        tick();

        // Basic write and read
        wa_en = 1'b1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        tick(); quiet();
        rd(5, 0);
        push("wr_data5", 32'hDEADBEEF); chk(rd_data[31:0]);
        push("wr_busy5", 0);            chk(XLEN'(rd_busy[0]));
        push("wr_data0", 0);            chk(rd_data[63:32]);

        // Collision: B wins
        wa_en = 1'b1; wa_addr = 7; wa_data = 32'h1111;
        wb_en = 1'b1; wb_addr = 7; wb_data = 32'h2222;
        tick(); quiet();
        rd(7, 5);
        push("coll_data7", 32'h2222);     chk(rd_data[31:0]);
        push("coll_keep5", 32'hDEADBEEF); chk(rd_data[63:32]);

        // Register 0 discards writes
        wa_en = 1'b1; wa_addr = 0; wa_data = '1;
        wb_en = 1'b1; wb_addr = 0; wb_data = '1;
        tick(); quiet();
        rd(0, 7);
        push("x0_data", 0);       chk(rd_data[31:0]);
        push("x0_busy", 0);       chk(XLEN'(rd_busy[0]));

        // Scoreboard behaviour
        sb_set_en = 1'b1; sb_set_addr = 9;
        rd(9, 0);
        push("sb_not_yet", 0);    chk(XLEN'(rd_busy[0]));
        tick(); quiet(); #1;
        push("sb_set9", 1);       chk(XLEN'(rd_busy[0]));
        wa_en = 1'b1; wa_addr = 9; wa_data = 32'h99;
        tick(); quiet(); #1;
        push("sb_wa_keeps", 1);   chk(XLEN'(rd_busy[0]));
        push("sb_wa_data", 32'h99); chk(rd_data[31:0]);
        wb_en = 1'b1; wb_addr = 9; wb_data = 32'h9B;
        tick(); quiet(); #1;
        push("sb_wb_clears", 0);  chk(XLEN'(rd_busy[0]));
        push("sb_wb_data", 32'h9B); chk(rd_data[31:0]);
        sb_set_en = 1'b1; sb_set_addr = 9;
        wb_en = 1'b1; wb_addr = 9; wb_data = 32'h9C;
        tick(); quiet(); #1;
        push("sb_set_wins", 1);   chk(XLEN'(rd_busy[0]));
        push("sb_set_wb_data", 32'h9C); chk(rd_data[31:0]);
        sb_set_en = 1'b1; sb_set_addr = 0;
        tick(); quiet();
        rd(0, 9);
        push("sb_x0_busy", 0);    chk(XLEN'(rd_busy[0]));
        push("sb_9_still", 1);    chk(XLEN'(rd_busy[1]));

        // Same-cycle bypass behaviour
        wa_en = 1'b1; wa_addr = 3; wa_data = 32'hA5A5A5A5;
        rd(3, 0);
`ifdef REGFILE_MP_BYPASS_EN
        push("byp_same", 32'hA5A5A5A5);
`else
        push("byp_same", 0);
`endif
        chk(rd_data[31:0]);
        tick(); quiet(); #1;
        push("byp_next", 32'hA5A5A5A5); chk(rd_data[31:0]);

        // Fill and clear
        for (int i = 1; i < NREG; i++) begin
            wa_en = 1'b1; wa_addr = AW'(i); wa_data = XLEN'(i);
            tick();
        end
        quiet();
        sb_set_en = 1'b1; sb_set_addr = 4;
        tick(); quiet();
        rd(17, 4);
        push("fill_17", 17);      chk(rd_data[31:0]);
        push("fill_busy4", 1);    chk(XLEN'(rd_busy[1]));
        clr_req = 1'b1;
        tick(); clr_req = 1'b0;
        wa_en = 1'b1; wa_addr = 10; wa_data = 32'h55;
        wb_en = 1'b1; wb_addr = 31; wb_data = 32'h77;
        sb_set_en = 1'b1; sb_set_addr = 12;
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        quiet();
        push("clr_cycles", 31);   chk(XLEN'(cnt));
        for (int i = 0; i < NREG; i++) begin
            rd(i, 0);
            push($sformatf("clr_data%0d", i), 0); chk(rd_data[31:0]);
            push($sformatf("clr_busy%0d", i), 0); chk(XLEN'(rd_busy[0]));
        end
        wa_en = 1'b1; wa_addr = 6; wa_data = 32'h66;
        tick(); quiet();
        rd(6, 0);
        push("post_clr_write", 32'h66); chk(rd_data[31:0]);

        // Reset in the middle of a clear
        wa_en = 1'b1; wa_addr = 20; wa_data = 32'h20;
        wb_en = 1'b1; wb_addr = 25; wb_data = 32'h25;
        sb_set_en = 1'b1; sb_set_addr = 30;
        tick(); quiet();
        clr_req = 1'b1;
        tick(); clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rd(20, 30);
        push("mid_busy_high", 1); chk(XLEN'(clr_busy));
        push("mid_20_kept", 32'h20); chk(rd_data[31:0]);
        push("mid_6_cleared", 0); rd(6, 30); chk(rd_data[31:0]);
        push("mid_30_busy", 1);   chk(XLEN'(rd_busy[1]));
        #1; rst = 1'b1; #1;
        push("rst_async_busy", 0); chk(XLEN'(clr_busy));
        rd(20, 25);
        push("rst_20", 0);        chk(rd_data[31:0]);
        push("rst_25", 0);        chk(rd_data[63:32]);
        rd(30, 0);
        push("rst_busy30", 0);    chk(XLEN'(rd_busy[0]));
        tick(); rst = 1'b0; tick();
        rd(20, 25);
        push("after_rst_20", 0);  chk(rd_data[31:0]);
        push("after_rst_clr", 0); chk(XLEN'(clr_busy));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined core. It replaces the single-write, two-read register file in the decode stage and has three write sources:
- port A: ALU writeback;
- port B: load writeback;
- scoreboard set: load issue.

It adds a per-register pending-load scoreboard and a sequential clear engine that zeroes the architectural state on request without a reset.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 4. AW = $clog2(NREG) is derived internally.
- NRD, 2, number of read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  scoreboard bit of the addressed register, combinational.
- wa_en / wa_addr / wa_data  in  1 / AW / XLEN  write port A (ALU).
- wb_en / wb_addr / wb_data  in  1 / AW / XLEN  write port B (load return).
- sb_set_en / sb_set_addr  in  1 / AW  mark register pending (load issued).
- clr_req  in  1  start sequential clear; single-cycle pulse or level.
- clr_busy  out  1  clear engine active.

## Operation
- Register 0 is hardwired zero:
  - writes to it are discarded;
  - its busy bit is never set;
  - reads of it return 0 and busy 0.
- Writes: on a clock edge, if wa_en, reg[wa_addr] <= wa_data; if wb_en, reg[wb_addr] <= wb_data.
- Same-address collision between A and B: port B wins.
- Scoreboard, evaluated per register per edge, in this order:
  - set by sb_set_en to that address; this wins over a same-cycle clear;
  - else cleared by a port-B write to that address;
  - port-A writes do not change busy.
- Reads: rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]]. Same-cycle bypass is as under Configuration.
- Clear FSM, two states:
  - IDLE: when clr_req is sampled high, go to CLEAR, with index = 1.
  - CLEAR: each cycle set reg[index] <= 0 and busy[index] <= 0, then increment index. When index = NREG-1 has been cleared, return to IDLE.
- While in CLEAR:
  - wa_en, wb_en and sb_set_en are ignored;
  - clr_req is ignored;
  - reads return current array contents, some registers already cleared and some not.
- Reset: all registers 0, all busy bits 0, FSM IDLE, index 0, clr_busy 0. After reset, all rd_data and rd_busy outputs are 0.
- Reset during CLEAR aborts immediately to the reset state.

## Timing
- Write latency: data written at edge N is readable from the array after edge N, i.e. in cycle N+1.
- Read latency: zero, combinational from rd_addr and array state.
- Busy latency: a set at edge N is visible on rd_busy in cycle N+1. Busy is never bypassed.
- clr_busy:
  - rises the cycle after clr_req is sampled;
  - stays high for exactly NREG-1 cycles;
  - falls when the FSM returns to IDLE;
  - writes are accepted again in the first cycle with clr_busy low.
- Back-to-back clr_req: a request sampled in the same cycle the FSM returns to IDLE starts a new clear.

## Configuration
- REGFILE_MP_BYPASS_EN defined:
  - rd_data[i] forwards same-cycle write data when the write is enabled, rd_addr[i] is nonzero, and it matches the write address;
  - on a collision, port B takes priority over port A;
  - bypass is suppressed while clr_busy is high.
- REGFILE_MP_BYPASS_EN undefined: rd_data reflects array contents only; a same-cycle write is visible the next cycle.

## Test plan
- Write and read: after reset, write A to reg 5 = 0xDEADBEEF. In the next cycle, rd_addr[0] = 5 gives rd_data[0] = 0xDEADBEEF and rd_busy[0] = 0. Reading reg 0 gives 0.
- Collision and x0:
  - wa and wb both write reg 7, A = 0x1111, B = 0x2222, so reg 7 reads 0x2222;
  - writing 0xFFFFFFFF to reg 0 on both ports still reads 0.
- Scoreboard:
  - sb_set reg 9, then rd_busy = 1 next cycle;
  - a port-A write to reg 9 leaves busy = 1;
  - a port-B write clears it;
  - sb_set and port-B write to reg 9 in the same cycle leaves busy = 1;
  - sb_set to reg 0 leaves busy = 0.
- Bypass: write A reg 3 = 0xA5A5A5A5 while reading reg 3 in the same cycle.
  - With REGFILE_MP_BYPASS_EN: 0xA5A5A5A5 the same cycle.
  - Without: the old value, 0, then 0xA5A5A5A5 next cycle.
- Clear:
  - fill regs 1..31 with their own index, set busy on reg 4, pulse clr_req;
  - clr_busy is high for exactly 31 cycles, and writes issued during it are dropped;
  - afterwards all regs read 0 and all busy bits are 0.
- Reset mid-clear: assert rst asynchronously 10 cycles into CLEAR. clr_busy drops immediately without waiting for a clock edge, and all registers read 0.
